// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and cache command signals of the load/store unit
interface load_store_unit_if #(
    parameter int ADDRESS_BITWIDTH       = 32,
    parameter int STALL_COUNTER_BITWIDTH = 32
);
    logic                              req_valid;
    logic                              req_ready;
    logic                              req_write;
    logic [2:0]                        req_funct3;
    logic [ADDRESS_BITWIDTH-1:0]       req_addr;
    logic [31:0]                       req_wdata;
    logic                              rsp_valid;
    logic [31:0]                       rsp_rdata;
    logic                              rsp_error;
    logic [STALL_COUNTER_BITWIDTH-1:0] stall_cycles;
    logic [ADDRESS_BITWIDTH-1:0]       address;
    logic [31:0]                       data_in;
    logic [3:0]                        write_enable;
    logic [31:0]                       data_out;
    logic                              data_out_ready;
    logic                              busy;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, data_out, data_out_ready, busy,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, stall_cycles, address, data_in, write_enable
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, data_out, data_out_ready, busy,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, stall_cycles, address, data_in, write_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V byte/half/word loads and stores onto a word-addressed cache port
module load_store_unit #(
    parameter int ADDRESS_BITWIDTH       = 32,
    parameter int STALL_COUNTER_BITWIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.master bus_io
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP} state_t;

    state_t                            state_q, state_d;
    logic [2:0]                        funct3_q;
    logic [1:0]                        off_q;
    logic                              write_q;
    logic                              rsp_error_q;
    logic [31:0]                       rsp_rdata_q;
    logic [31:0]                       data_in_q;
    logic [ADDRESS_BITWIDTH-1:0]       address_q;
    logic [3:0]                        write_enable_q;
    logic [STALL_COUNTER_BITWIDTH-1:0] stall_q;
    logic                              ready, accept, done, bad;
    logic [2:0]                        req_f;
    logic [1:0]                        req_off;
    logic [3:0]                        req_be;
    logic [31:0]                       req_wd, rd_ext;
    logic [7:0]                        rd_byte;
    logic [15:0]                       rd_half;

    assign ready                 = rst_n && state_q == IDLE && !bus_io.busy;
    assign bus_io.req_ready      = ready;
    assign bus_io.rsp_valid      = state_q == RESP;
    assign bus_io.rsp_rdata      = rsp_rdata_q;
    assign bus_io.rsp_error      = rsp_error_q;
    assign bus_io.stall_cycles   = stall_q;
    assign bus_io.address        = address_q;
    assign bus_io.data_in        = data_in_q;
    assign bus_io.write_enable   = write_enable_q;

    // Decode the incoming request: legality, alignment, store strobes and replicated store data
    always_comb begin
        req_f   = bus_io.req_funct3;
        req_off = bus_io.req_addr[1:0];
        bad     = req_f == 3'b011 || req_f[2:1] == 2'b11 || (bus_io.req_write && req_f[2])
                  || (req_f[1:0] == 2'b01 && req_off[0]) || (req_f[1:0] == 2'b10 && req_off != 2'b00);
        req_be  = req_f[1:0] == 2'b00 ? 4'b0001 << req_off :
                  req_f[1:0] == 2'b01 ? 4'b0011 << req_off : 4'b1111;
        req_wd  = req_f[1:0] == 2'b00 ? {4{bus_io.req_wdata[7:0]}} :
                  req_f[1:0] == 2'b01 ? {2{bus_io.req_wdata[15:0]}} : bus_io.req_wdata;
    end

    // Pick the addressed byte/half out of the returned word and extend it
    always_comb begin
        rd_byte = bus_io.data_out[{off_q, 3'b000} +: 8];
        rd_half = bus_io.data_out[{off_q[1], 4'b0000} +: 16];
        rd_ext  = funct3_q[1:0] == 2'b00 ? {{24{rd_byte[7] & ~funct3_q[2]}}, rd_byte} :
                  funct3_q[1:0] == 2'b01 ? {{16{rd_half[15] & ~funct3_q[2]}}, rd_half} : bus_io.data_out;
    end

    // State register
    always_ff @(posedge clk) begin
        state_q <= !rst_n ? IDLE : state_d;
    end

    // Next state plus accept/complete strobes for the datapath
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                accept  = bus_io.req_valid && ready;
                state_d = !accept ? IDLE : bad ? RESP : ISSUE;
            end
            ISSUE:   state_d = write_q ? WAIT_WR : WAIT_RD;
            WAIT_RD: begin
                done    = bus_io.data_out_ready && !bus_io.busy;
                state_d = done ? RESP : WAIT_RD;
            end
            WAIT_WR: begin
                done    = !bus_io.busy;
                state_d = done ? RESP : WAIT_WR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the request, hold the cache command until completion, capture load data, count stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            funct3_q       <= '0;
            off_q          <= '0;
            write_q        <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            data_in_q      <= '0;
            address_q      <= '0;
            write_enable_q <= '0;
            stall_q        <= '0;
        end else begin
            if (accept) begin
                funct3_q    <= req_f;
                off_q       <= req_off;
                write_q     <= bus_io.req_write;
                rsp_error_q <= bad;
                rsp_rdata_q <= '0;
                if (!bad) begin
                    address_q      <= {bus_io.req_addr[ADDRESS_BITWIDTH-1:2], 2'b00};
                    data_in_q      <= bus_io.req_write ? req_wd : '0;
                    write_enable_q <= bus_io.req_write ? req_be : 4'b0000;
                end
            end
            if (done) write_enable_q <= 4'b0000;
            if (done && state_q == WAIT_RD) rsp_rdata_q <= rd_ext;
            if ((state_q == WAIT_RD || state_q == WAIT_WR) && !done) stall_q <= stall_q + 1'b1;
        end
    end
endmodule
